// File: rtl/pulse_rings_pkg.sv
// Shared widths, ring status record and colour fade helper for the pulse_rings layer.
package pulse_rings_pkg;

   localparam int unsigned H_W   = 11;
   localparam int unsigned V_W   = 10;
   localparam int unsigned PIX_W = 24;
   localparam int unsigned T_W   = 10;
   localparam int unsigned PH_W  = 8;
   localparam int unsigned R_W   = 11;
   localparam int unsigned SQ_W  = 22;
   // One spare bit so far off-screen coordinates cannot wrap back onto a ring.
   localparam int unsigned D2_W  = 23;

   typedef struct packed {
      logic            hit;
      logic [PH_W-1:0] phase;
   } ring_hit_t;

   function automatic logic [PIX_W-1:0] scale_color(input logic [PIX_W-1:0] color,
                                                    input logic [PH_W-1:0]  phase);
      logic [PH_W-1:0]  level;
      logic [15:0]      prod;
      logic [PIX_W-1:0] res;
      level = 8'd255 - phase;
      res   = '0;
      for (int c = 0; c < 3; c++) begin
         prod            = {8'd0, color[c*8 +: 8]} * {8'd0, level};
         res[c*8 +: 8]   = prod[15:8];
      end
      return res;
   endfunction

endpackage

// File: rtl/pulse_rings_if.sv
// Video-side bundle of pulse_rings: frame sync, tempo, raster position in; pixel, phase out.
interface pulse_rings_if;
   import pulse_rings_pkg::*;

   logic             vsync;
   logic [T_W-1:0]   tempo;
   logic [H_W-1:0]   hcount;
   logic [V_W-1:0]   vcount;
   logic [PIX_W-1:0] pixel;
   logic [PH_W-1:0]  count;

   modport master (
      output vsync, tempo, hcount, vcount,
      input  pixel, count
   );

   modport slave (
      input  vsync, tempo, hcount, vcount,
      output pixel, count
   );

endinterface

// File: rtl/pulse_rings_ring_shade.sv
// One ring: phase -> registered inner/outer squared radii, then a registered hit flag
// carrying the ring phase for the fade and winner stages.
module pulse_rings_ring_shade
   import pulse_rings_pkg::*;
#(
   parameter int unsigned RAD_MIN = 20,
   parameter int unsigned THICK   = 15
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [PH_W-1:0] i_phase,
   input  logic [D2_W-1:0] i_d2,
   output ring_hit_t       o_ring
);

   logic [R_W-1:0]  w_r_out;
   logic [R_W-1:0]  w_r_in;
   logic [SQ_W-1:0] w_r_out_ext;
   logic [SQ_W-1:0] w_r_in_ext;
   logic [D2_W-1:0] w_sq_out_ext;
   logic [D2_W-1:0] w_sq_in_ext;

   logic [R_W-1:0]  r_r_out;
   logic [R_W-1:0]  r_r_in;
   logic [PH_W-1:0] r_ph1;
   logic [SQ_W-1:0] r_sq_out;
   logic [SQ_W-1:0] r_sq_in;
   logic [PH_W-1:0] r_ph2;
   ring_hit_t       r_ring;

   assign w_r_out      = R_W'(RAD_MIN) + R_W'(i_phase);
   assign w_r_in       = (w_r_out >= R_W'(THICK)) ? w_r_out - R_W'(THICK) : '0;
   assign w_r_out_ext  = SQ_W'(r_r_out);
   assign w_r_in_ext   = SQ_W'(r_r_in);
   assign w_sq_out_ext = D2_W'(r_sq_out);
   assign w_sq_in_ext  = D2_W'(r_sq_in);

   // Phase travels alongside the radii so hit and fade always describe the same ring state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_r_out  <= '0;
         r_r_in   <= '0;
         r_ph1    <= '0;
         r_sq_out <= '0;
         r_sq_in  <= '0;
         r_ph2    <= '0;
         r_ring   <= '0;
      end else begin
         r_r_out      <= w_r_out;
         r_r_in       <= w_r_in;
         r_ph1        <= i_phase;
         r_sq_out     <= w_r_out_ext * w_r_out_ext;
         r_sq_in      <= w_r_in_ext * w_r_in_ext;
         r_ph2        <= r_ph1;
         r_ring.hit   <= (w_sq_in_ext <= i_d2) && (i_d2 <= w_sq_out_ext);
         r_ring.phase <= r_ph2;
      end
   end

   assign o_ring = r_ring;

endmodule

// File: rtl/pulse_rings.sv
// Tempo-driven concentric ring generator: frame tick, phase accumulator, distance
// pipeline and lowest-phase winner select feeding a registered pixel.
module pulse_rings
   import pulse_rings_pkg::*;
#(
   parameter int unsigned      NUM_RINGS   = 4,
   parameter logic [PIX_W-1:0] COLOR       = 24'hFFFFFF,
   parameter int unsigned      X           = 400,
   parameter int unsigned      Y           = 300,
   parameter int unsigned      RAD_MIN     = 20,
   parameter int unsigned      THICK       = 15,
   parameter int unsigned      START       = 0,
   parameter int unsigned      TEMPO_SHIFT = 4,
   parameter int unsigned      FADE        = 1
) (
   input logic           clk,
   input logic           reset,
   pulse_rings_if.slave  bus
);

   localparam int unsigned SPACING = 256 / NUM_RINGS;
   localparam int unsigned DLY_W   = (START > 0) ? $clog2(START + 1) : 1;

   logic                r_vsync;
   logic [DLY_W-1:0]    r_delay;
   logic [PH_W-1:0]     r_base;
   logic [H_W-1:0]      r_dx;
   logic [V_W-1:0]      r_dy;
   logic [D2_W-1:0]     r_d2;
   logic [PIX_W-1:0]    r_pixel;

   logic                w_tick;
   logic [PH_W-1:0]     w_step;
   logic [H_W-1:0]      w_dx;
   logic [V_W-1:0]      w_dy;
   logic [D2_W-1:0]     w_dx_ext;
   logic [D2_W-1:0]     w_dy_ext;
   logic [PH_W-1:0]     w_phase [NUM_RINGS];
   ring_hit_t           w_rings [NUM_RINGS];
   logic                w_win_hit;
   logic [PH_W-1:0]     w_win_phase;
   logic [PIX_W-1:0]    w_color;

   assign w_tick = bus.vsync & ~r_vsync;
   assign w_step = PH_W'(bus.tempo >> TEMPO_SHIFT);

   // Detector resets to "already high" so a vsync held through reset release cannot tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_vsync <= 1'b1;
         r_delay <= '0;
         r_base  <= '0;
      end else begin
         r_vsync <= bus.vsync;
         if (w_tick) begin
            if (32'(r_delay) < START) begin
               r_delay <= r_delay + DLY_W'(1);
            end else begin
               r_base <= r_base + w_step;
            end
         end
      end
   end

   assign w_dx     = (bus.hcount >= H_W'(X)) ? bus.hcount - H_W'(X) : H_W'(X) - bus.hcount;
   assign w_dy     = (bus.vcount >= V_W'(Y)) ? bus.vcount - V_W'(Y) : V_W'(Y) - bus.vcount;
   assign w_dx_ext = D2_W'(r_dx);
   assign w_dy_ext = D2_W'(r_dy);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_dx <= '0;
         r_dy <= '0;
         r_d2 <= '0;
      end else begin
         r_dx <= w_dx;
         r_dy <= w_dy;
         r_d2 <= w_dx_ext * w_dx_ext + w_dy_ext * w_dy_ext;
      end
   end

   for (genvar g = 0; g < NUM_RINGS; g++) begin : g_ring
      assign w_phase[g] = r_base + PH_W'(g * SPACING);

      pulse_rings_ring_shade #(
         .RAD_MIN (RAD_MIN),
         .THICK   (THICK)
      ) u_shade (
         .clk     (clk),
         .reset   (reset),
         .i_phase (w_phase[g]),
         .i_d2    (r_d2),
         .o_ring  (w_rings[g])
      );
   end

   // Strict less-than while scanning upward leaves ties with the lowest index.
   always_comb begin
      w_win_hit   = 1'b0;
      w_win_phase = '0;
      for (int unsigned i = 0; i < NUM_RINGS; i++) begin
         if (w_rings[i].hit && (!w_win_hit || (w_rings[i].phase < w_win_phase))) begin
            w_win_hit   = 1'b1;
            w_win_phase = w_rings[i].phase;
         end
      end
   end

   assign w_color = (FADE != 0) ? scale_color(COLOR, w_win_phase) : COLOR;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pixel <= '0;
      end else begin
         r_pixel <= w_win_hit ? w_color : '0;
      end
   end

   assign bus.pixel = r_pixel;
   assign bus.count = r_base;

endmodule

// File: tb/tb_pulse_rings.sv
// Directed bench: two pulse_rings variants share stimulus; vector tables plus
// hand-written tick, latency and reset sequences.
module tb_pulse_rings;

   localparam logic [23:0] CA = 24'h12AB34;

   typedef struct {
      logic [10:0] hc;
      logic [9:0]  vc;
      logic [23:0] exp_a;
      logic [23:0] exp_b;
   } vec_t;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   pulse_rings_if bus_a ();
   pulse_rings_if bus_b ();

   // A: single ring, no fade. B: four wide rings with fade, three-frame start delay.
   pulse_rings #(
      .NUM_RINGS (1),
      .COLOR     (CA),
      .FADE      (0)
   ) u_dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   pulse_rings #(
      .NUM_RINGS (4),
      .COLOR     (24'hFF8040),
      .THICK     (80),
      .START     (3),
      .FADE      (1)
   ) u_dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pos(input logic [10:0] hc, input logic [9:0] vc);
      bus_a.hcount = hc;
      bus_b.hcount = hc;
      bus_a.vcount = vc;
      bus_b.vcount = vc;
   endtask

   task automatic set_vsync(input logic v);
      bus_a.vsync = v;
      bus_b.vsync = v;
   endtask

   task automatic set_tempo(input logic [9:0] t);
      bus_a.tempo = t;
      bus_b.tempo = t;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int hold);
      set_vsync(1'b1);
      repeat (hold) step();
      set_vsync(1'b0);
      repeat (2) step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      step();
   endtask

   task automatic apply_vec(input string tag, input int idx, input vec_t v);
      set_pos(v.hc, v.vc);
      repeat (4) step();
      check($sformatf("%s[%0d] pixel_a", tag, idx), 32'(bus_a.pixel), 32'(v.exp_a));
      check($sformatf("%s[%0d] pixel_b", tag, idx), 32'(bus_b.pixel), 32'(v.exp_b));
   endtask

   task automatic check_counts(input string tag, input logic [7:0] ea, input logic [7:0] eb);
      check({tag, " count_a"}, 32'(bus_a.count), 32'(ea));
      check({tag, " count_b"}, 32'(bus_b.count), 32'(eb));
   endtask

   vec_t tbl_base0 [14];
   vec_t tbl_d     [4];
   vec_t tbl_e     [5];

   initial begin
      n_checks = 0;
      n_fail   = 0;

      // Base 0. A: ring [5,20]. B: rings [0,20] [4,84] [68,148] [132,212].
      tbl_base0[0]  = '{11'd410, 10'd300, CA,    24'hFE7F3F};
      tbl_base0[1]  = '{11'd400, 10'd300, 24'h0, 24'hFE7F3F};
      tbl_base0[2]  = '{11'd400, 10'd320, CA,    24'hFE7F3F};
      tbl_base0[3]  = '{11'd480, 10'd300, 24'h0, 24'hBE5F2F};
      tbl_base0[4]  = '{11'd540, 10'd300, 24'h0, 24'h7E3F1F};
      tbl_base0[5]  = '{11'd550, 10'd300, 24'h0, 24'h3E1F0F};
      tbl_base0[6]  = '{11'd400, 10'd90,  24'h0, 24'h3E1F0F};
      tbl_base0[7]  = '{11'd613, 10'd300, 24'h0, 24'h0};
      tbl_base0[8]  = '{11'd394, 10'd292, CA,    24'hFE7F3F};
      tbl_base0[9]  = '{11'd404, 10'd303, CA,    24'hFE7F3F};
      tbl_base0[10] = '{11'd403, 10'd302, 24'h0, 24'hFE7F3F};
      tbl_base0[11] = '{11'd400, 10'd280, CA,    24'hFE7F3F};
      tbl_base0[12] = '{11'd421, 10'd300, 24'h0, 24'hBE5F2F};
      tbl_base0[13] = '{11'd548, 10'd300, 24'h0, 24'h7E3F1F};

      // A after one tick of step 10: ring [15,30]. B still at base 0.
      tbl_d[0] = '{11'd430, 10'd300, CA,    24'hBE5F2F};
      tbl_d[1] = '{11'd415, 10'd300, CA,    24'hFE7F3F};
      tbl_d[2] = '{11'd414, 10'd300, 24'h0, 24'hFE7F3F};
      tbl_d[3] = '{11'd431, 10'd300, 24'h0, 24'hBE5F2F};

      // A base 59: ring [64,79]. B base 126: phases 126,190,254,62.
      tbl_e[0] = '{11'd479, 10'd300, CA,    24'hC06030};
      tbl_e[1] = '{11'd464, 10'd300, CA,    24'hC06030};
      tbl_e[2] = '{11'd463, 10'd300, 24'h0, 24'hC06030};
      tbl_e[3] = '{11'd480, 10'd300, 24'h0, 24'hC06030};
      tbl_e[4] = '{11'd600, 10'd300, 24'h0, 24'h402010};

      reset = 1'b1;
      set_vsync(1'b0);
      set_tempo(10'd0);
      set_pos(11'd0, 10'd0);
      repeat (3) step();
      check("reset pixel_a", 32'(bus_a.pixel), 32'h0);
      check("reset pixel_b", 32'(bus_b.pixel), 32'h0);
      check_counts("reset", 8'd0, 8'd0);
      reset = 1'b0;
      step();

      foreach (tbl_base0[i]) apply_vec("base0", i, tbl_base0[i]);

      // Step 0 ticks: tempo just below one step.
      set_tempo(10'd15);
      for (int i = 0; i < 4; i++) begin
         tick(2);
         check_counts($sformatf("step0 tick%0d", i), 8'd0, 8'd0);
      end
      foreach (tbl_base0[i]) apply_vec("base0 again", i, tbl_base0[i]);

      // Start delay on B, long vsync counted once.
      do_reset();
      set_tempo(10'd160);
      tick(2);
      check_counts("delay t1", 8'd10, 8'd0);
      tick(100);
      check_counts("delay t2 long", 8'd20, 8'd0);
      tick(2);
      check_counts("delay t3", 8'd30, 8'd0);
      tick(2);
      check_counts("delay t4", 8'd40, 8'd10);

      do_reset();
      tick(2);
      check_counts("single tick", 8'd10, 8'd0);
      foreach (tbl_d[i]) apply_vec("edges", i, tbl_d[i]);

      // Exact four-clock latency with a one-clock coordinate pulse.
      set_pos(11'd0, 10'd0);
      repeat (5) step();
      set_pos(11'd430, 10'd300);
      step();
      set_pos(11'd0, 10'd0);
      step();
      step();
      check("latency clk3", 32'(bus_a.pixel), 32'h0);
      step();
      check("latency clk4", 32'(bus_a.pixel), 32'(CA));
      step();
      check("latency clk5", 32'(bus_a.pixel), 32'h0);

      do_reset();
      set_tempo(10'd1023);
      for (int i = 0; i < 5; i++) tick(2);
      check_counts("wrap 5 ticks", 8'd59, 8'd126);
      foreach (tbl_e[i]) apply_vec("wrap", i, tbl_e[i]);

      // Mid-line reset, with vsync rising on the reset clock and held through release.
      set_pos(11'd470, 10'd300);
      repeat (5) step();
      check("pre-reset pixel_a", 32'(bus_a.pixel), 32'(CA));
      check("pre-reset pixel_b", 32'(bus_b.pixel), 32'hC06030);
      reset = 1'b1;
      set_vsync(1'b1);
      step();
      check("mid reset pixel_a", 32'(bus_a.pixel), 32'h0);
      check("mid reset pixel_b", 32'(bus_b.pixel), 32'h0);
      check_counts("mid reset", 8'd0, 8'd0);
      step();
      reset = 1'b0;
      repeat (5) step();
      check_counts("vsync high at release", 8'd0, 8'd0);
      set_vsync(1'b0);
      repeat (2) step();
      set_vsync(1'b1);
      step();
      check_counts("fresh edge", 8'd63, 8'd0);
      set_vsync(1'b0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
